// File: rtl/dav_pkg.sv
// Shared types and defaults for the per-frame FFT sequencer.
// Imported by the sequencer top and by its testbench.
package dav_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StStart,
        StBusy,
        StSwap,
        StRecover
    } seq_state_e;

    localparam int unsigned FFT_TIMEOUT    = 64;
    localparam int unsigned FFT_RST_CYCLES = 2;
    localparam int unsigned FFT_CNT_W      = 8;

endpackage

// File: rtl/toggle_edge_sync.sv
// Brings an asynchronous toggle into the clk domain.
// Emits a one-cycle pulse for each toggle edge.
module toggle_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    output logic pulse_o
);

    // [1:0] form the synchronizer; [2] holds the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], toggle_i};
        end
    end

    assign pulse_o = sync_q[2] ^ sync_q[1];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Runs one FFT per display frame: snapshot, start, watchdogged wait, bank swap.
// Hung transforms are recovered by pulsing the FFT core reset.
module fft_frame_sequencer
    import dav_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = FFT_TIMEOUT,
    parameter int unsigned RST_CYCLES     = FFT_RST_CYCLES,
    parameter int unsigned CNT_W          = FFT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_toggle,
    input  logic             run,
    input  logic             fft_done,
    output logic             snap_en,
    output logic             fft_start,
    output logic             fft_rst,
    output logic             bank_sel,
    output logic             frame_valid,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned RcW = $clog2(RST_CYCLES) + 1;

    localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [RcW-1:0]   RcLast = RcW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    seq_state_e       state_q, state_d;
    logic             req;
    logic             capture;
    logic             pending_q, pending_d;
    logic             armed_q, armed_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [RcW-1:0]   rc_q, rc_d;
    logic             bank_q, bank_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             in_rst_q;

    toggle_edge_sync u_frame_sync (
        .clk      (clk),
        .rst      (rst),
        .toggle_i (frame_toggle),
        .pulse_o  (req)
    );

    assign capture = req && run;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (pending_q) state_d = StSnap;
            StSnap:    state_d = StStart;
            StStart:   state_d = StBusy;
            StBusy: begin
                // Completion takes priority over an expiring watchdog.
                if (armed_q && fft_done) begin
                    state_d = StSwap;
                end else if (wd_q == WdLast) begin
                    state_d = StRecover;
                end
            end
            StSwap:    state_d = StIdle;
            StRecover: if (rc_q == RcLast) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Request capture, watchdog, recovery timer, bank and counters
    always_comb begin
        pending_d = pending_q;
        armed_d   = armed_q;
        wd_d      = wd_q;
        rc_d      = rc_q;
        bank_d    = bank_q;
        drop_d    = drop_q;
        tmo_d     = tmo_q;

        if (state_q == StIdle && pending_q) pending_d = 1'b0;
        if (capture) pending_d = 1'b1;
        if (capture && pending_q && drop_q != CntMax) drop_d = drop_q + CNT_W'(1);

        case (state_q)
            StStart: begin
                armed_d = 1'b0;
                wd_d    = '0;
            end
            StBusy: begin
                wd_d = wd_q + WdW'(1);
                // A done level left over from the previous frame must drop first.
                if (!fft_done) armed_d = 1'b1;
                if (state_d == StSwap) bank_d = ~bank_q;
                if (state_d == StRecover) begin
                    rc_d = '0;
                    if (tmo_q != CntMax) tmo_d = tmo_q + CNT_W'(1);
                end
            end
            StRecover: rc_d = rc_q + RcW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 1'b0;
            armed_q   <= 1'b0;
            wd_q      <= '0;
            rc_q      <= '0;
            bank_q    <= 1'b0;
            drop_q    <= '0;
            tmo_q     <= '0;
            in_rst_q  <= 1'b1;
        end else begin
            pending_q <= pending_d;
            armed_q   <= armed_d;
            wd_q      <= wd_d;
            rc_q      <= rc_d;
            bank_q    <= bank_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            in_rst_q  <= 1'b0;
        end
    end

    // Outputs
    always_comb begin
        snap_en     = (state_q == StSnap);
        fft_start   = (state_q == StStart);
        frame_valid = (state_q == StSwap);
        busy        = (state_q != StIdle);
        fft_rst     = in_rst_q || (state_q == StRecover);
        bank_sel    = bank_q;
        drop_cnt    = drop_q;
        timeout_cnt = tmo_q;
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed-plus-random bench for fft_frame_sequencer with a frame-level model
// tracking expected bank, drop and timeout counts.
module tb_fft_frame_sequencer;
    import dav_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_toggle;
    logic             run;
    logic             fft_done;
    logic             snap_en;
    logic             fft_start;
    logic             fft_rst;
    logic             bank_sel;
    logic             frame_valid;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    int n_pass  = 0;
    int n_total = 0;

    bit exp_bank    = 1'b0;
    int exp_drop    = 0;
    int exp_timeout = 0;

    fft_frame_sequencer #(
        .TIMEOUT_CYCLES (FFT_TIMEOUT),
        .RST_CYCLES     (2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_toggle (frame_toggle),
        .run          (run),
        .fft_done     (fft_done),
        .snap_en      (snap_en),
        .fft_start    (fft_start),
        .fft_rst      (fft_rst),
        .bank_sel     (bank_sel),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .drop_cnt     (drop_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Optionally toggles, waits for snap_en, then expects fft_start the cycle after.
    task automatic start_frame(input bit do_toggle, input int exp_lat);
        int n = 0;
        if (do_toggle) frame_toggle = ~frame_toggle;
        while (snap_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (exp_lat >= 0) check("snap_latency", n, exp_lat);
        else check("snap_seen", snap_en, 1);
        step();
        check("fft_start", fft_start, 1);
        check("snap_single", snap_en, 0);
    endtask

    // Called at the fft_start sample; raises done d cycles later and expects the swap at d+1.
    task automatic run_frame(input int d, input int tog_n, input bit run_off, input bit keep_done);
        int early = 0;
        for (int i = 1; i <= d; i++) begin
            step();
            if (frame_valid === 1'b1) early++;
            if (tog_n > 0 && i >= 2 && (i - 2) % 4 == 0 && (i - 2) / 4 < tog_n)
                frame_toggle = ~frame_toggle;
            if (run_off && i == 3) run = 1'b0;
            if (i == d) fft_done = 1'b1;
        end
        step();
        exp_bank = ~exp_bank;
        check("no_early_fv", early, 0);
        check("frame_valid", frame_valid, 1);
        check("bank_sel_swap", bank_sel, exp_bank);
        if (!keep_done) fft_done = 1'b0;
    endtask

    initial begin
        int cnt;
        int d;
        int n;

        rst          = 1'b0;
        frame_toggle = 1'b0;
        run          = 1'b1;
        fft_done     = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_fft_rst", fft_rst, 1);
        check("rst_bank", bank_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_timeout", timeout_cnt, 0);
        check("rst_snap", snap_en, 0);
        check("rst_fv", frame_valid, 0);
        rst = 1'b1;
        step();
        check("rel_fft_rst", fft_rst, 0);
        repeat (3) step();

        // Nominal frame, done 10 cycles after start
        start_frame(1'b1, 4);
        run_frame(10, 0, 1'b0, 1'b0);
        step();
        check("nominal_idle", busy, 0);

        // Random transform lengths
        repeat (4) begin
            d = $urandom_range(2, 20);
            start_frame(1'b1, 4);
            run_frame(d, 0, 1'b0, 1'b0);
            repeat ($urandom_range(1, 5)) step();
        end

        // Stale done held high from the previous frame
        start_frame(1'b1, 4);
        run_frame(6, 0, 1'b0, 1'b1);
        start_frame(1'b1, 4);
        cnt = 0;
        repeat (8) begin
            step();
            if (frame_valid === 1'b1) cnt++;
        end
        fft_done = 1'b0;
        repeat (2) step();
        fft_done = 1'b1;
        repeat (4) begin
            step();
            if (frame_valid === 1'b1) cnt++;
        end
        exp_bank = ~exp_bank;
        check("stale_fv_count", cnt, 1);
        check("stale_bank", bank_sel, exp_bank);
        fft_done = 1'b0;
        repeat (3) step();

        // Coalescing: three requests during one transform
        check("drop_before", drop_cnt, exp_drop);
        start_frame(1'b1, 4);
        run_frame(20, 3, 1'b0, 1'b0);
        exp_drop += 2;
        check("coalesce_drop", drop_cnt, exp_drop);
        start_frame(1'b0, -1);
        run_frame(5, 0, 1'b0, 1'b0);
        cnt = 0;
        repeat (20) begin
            step();
            if (snap_en === 1'b1) cnt++;
        end
        check("coalesce_one_followup", cnt, 0);

        // Random number of coalesced requests
        n = $urandom_range(1, 4);
        start_frame(1'b1, 4);
        run_frame(20, n, 1'b0, 1'b0);
        exp_drop += n - 1;
        check("rand_coalesce_drop", drop_cnt, exp_drop);
        start_frame(1'b0, -1);
        run_frame($urandom_range(2, 12), 0, 1'b0, 1'b0);
        repeat (3) step();

        // Watchdog timeout with a request queued during the hung transform
        start_frame(1'b1, 4);
        cnt = 0;
        while (fft_rst !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
            if (cnt == 3) frame_toggle = ~frame_toggle;
        end
        exp_timeout++;
        check("timeout_entry", cnt, FFT_TIMEOUT + 1);
        check("timeout_cnt", timeout_cnt, exp_timeout);
        check("timeout_bank", bank_sel, exp_bank);
        check("timeout_no_fv", frame_valid, 0);
        cnt = 0;
        while (fft_rst === 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check("recover_len", cnt, 2);
        start_frame(1'b0, -1);
        run_frame($urandom_range(2, 10), 0, 1'b0, 1'b0);
        check("retry_drop", drop_cnt, exp_drop);
        repeat (3) step();

        // run deasserted mid-transform
        start_frame(1'b1, 4);
        run_frame(8, 0, 1'b1, 1'b0);
        repeat (2) begin
            repeat (4) step();
            frame_toggle = ~frame_toggle;
        end
        cnt = 0;
        repeat (20) begin
            step();
            if (snap_en === 1'b1) cnt++;
        end
        check("run_off_no_snap", cnt, 0);
        check("run_off_drop", drop_cnt, exp_drop);
        run = 1'b1;

        // Reset mid-transform
        start_frame(1'b1, 4);
        repeat (3) step();
        rst          = 1'b0;
        frame_toggle = 1'b0;
        step();
        exp_bank = 1'b0;
        exp_drop = 0;
        check("midrst_busy", busy, 0);
        check("midrst_fv", frame_valid, 0);
        check("midrst_bank", bank_sel, exp_bank);
        check("midrst_fft_rst", fft_rst, 1);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midrst_release", fft_rst, 0);
        check("midrst_drop", drop_cnt, exp_drop);
        check("midrst_timeout", timeout_cnt, 0);

        // Drop counter saturation with 300 excess requests
        repeat (301) begin
            frame_toggle = ~frame_toggle;
            repeat (2) step();
        end
        repeat (5) step();
        check("drop_saturate", drop_cnt, (1 << CNT_W) - 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
